conv_encoder_multirate: RTL and testbench
=========================================

Name: conv_encoder_multirate

Overview:
- Parametrised IEEE 802.11 convolutional encoder (K=7) with puncturing for rates 1/2, 2/3 and 3/4.
- Sits between the scrambler and the interleaver on AXI-Stream.
- Generalises the fixed-width half/three-quarter encoder:
  - configurable width and generators;
  - adds rate 2/3 (48M);
  - rate is latched per packet;
  - encoder state is cleared on tlast;
  - 2-entry output skid buffer gives full throughput under backpressure.

Parameters:
- WIDTH, 24, input bits per beat; must be a multiple of 6 (checked at elaboration).
- GEN_A, 7'o133, generator A; MSB = current bit, LSB = delay 6.
- GEN_B, 7'o171, generator B; same bit ordering as GEN_A.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  WIDTH  uncoded bits; bit 0 is first in time
- s_axis_tuser  in  4  802.11 RATE code
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last beat of packet
- m_axis_tdata  out  2*WIDTH  coded bits, LSB-packed, first in time at bit 0; unused MSBs are 0
- m_axis_tuser  out  4  latched RATE code for this beat
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  passes s_axis_tlast through

Behaviour:
- Reset (aresetn low, asynchronous): clears shift state, skid buffer, rate latch and the in-packet flag.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0.
  - s_axis_tready=0 while reset is asserted, 1 on the first cycle after release.
- Encoding, per input bit x_n: A_n = XOR of GEN_A taps over x_n..x_{n-6}; B_n likewise with GEN_B.
  - Unpunctured order is A0 B0 A1 B1 ...
  - The 6-bit history carries across beats within a packet.
- Rate mapping:
  - 1101/0101/1001 (6/12/24M): rate 1/2, 2*WIDTH bits.
  - 0001 (48M): rate 2/3, keep A0 B0 A1 per 2 input bits, 3*WIDTH/2 bits.
  - 1111/0111/1011/0011 (9/18/36/54M): rate 3/4, keep A0 B0 A1 B2 per 3 input bits, 4*WIDTH/3 bits.
  - Any other code: rate 1/2.
  - Puncture phase restarts at bit 0 of every beat; this is valid because WIDTH%6==0.
- Rate latch:
  - s_axis_tuser is sampled on the first accepted beat of a packet (in-packet flag clear).
  - It is held until the beat carrying tlast is accepted.
  - tuser changes mid-packet are ignored.
- tlast handling: acceptance of a tlast beat zeroes the shift history after that beat is encoded, and clears the in-packet flag.
- Latency: beat accepted at edge N appears on m_axis at edge N+1 if the buffer was empty.
- Handshake:
  - s_axis_tready = (buffer occupancy < 2), registered; no combinational path from m_axis_tready.
  - Transfer occurs on valid&&ready on both sides.
  - m_axis_tdata, m_axis_tuser and m_axis_tlast are stable while m_axis_tvalid && !m_axis_tready.
- Buffer, 2 entries, FIFO order:
  - Simultaneous push and pop at occupancy 1 or 2 keeps occupancy unchanged.
  - At occupancy 2, a pop frees one slot and ready returns the following cycle.
  - One beat per clock is sustained with m_axis_tready held high.
- Reset mid-packet: the partial packet is discarded and the next accepted beat starts a new packet with zero history.

Test Plan:
- WIDTH=24, RATE_6M, tdata=24'h000001, tlast=1 -> m_axis_tdata=48'h0000000034FB, tuser=4'b1101, one cycle latency.
- RATE_9M, tdata=24'h000001, tlast=1 -> m_axis_tdata=48'h00000000033B.
- RATE_48M, tdata=24'h000001, tlast=1 -> m_axis_tdata=48'h00000000073B.
- History carry-over:
  - RATE_6M, beat0=24'h800000 with tlast=0, beat1=0 with tlast=1 -> out0=48'hC00000000000, out1=48'h000000000D3E.
  - Same stimulus with tlast=1 on beat0 -> out1=0.
- Backpressure:
  - Stream 10 beats with m_axis_tready toggling 1-in-3; s_axis_tready drops only at occupancy 2.
  - Outputs arrive in order and unchanged while stalled; m_axis_tready=1 throughout -> 10 outputs in 10 consecutive cycles.
- Rate latch and reset:
  - Change tuser from RATE_6M to RATE_9M on beat 2 of a 3-beat packet -> all three outputs at rate 1/2.
  - Assert aresetn low mid-packet -> m_axis_tvalid=0 immediately; next packet's impulse output matches the first scenario.

Source files
------------

// File: rtl/conv_encoder_multirate.sv
// K=7 convolutional encoder with 802.11 puncturing (1/2, 2/3, 3/4) on AXI-Stream.
// The per-packet rate latch and the shift history feed a 2-entry output skid buffer.
module conv_encoder_multirate #(
  parameter int         WIDTH = 24,
  parameter logic [6:0] GEN_A = 7'o133,
  parameter logic [6:0] GEN_B = 7'o171
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [WIDTH-1:0]     s_axis_tdata,
  input  logic [3:0]           s_axis_tuser,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [2*WIDTH-1:0]   m_axis_tdata,
  output logic [3:0]           m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast
);

  localparam int OW  = 2 * WIDTH;
  localparam int W23 = 3 * WIDTH / 2;
  localparam int W34 = 4 * WIDTH / 3;

  if (WIDTH % 6 != 0) begin : g_bad_width
    $error("conv_encoder_multirate: WIDTH must be a multiple of 6");
  end

  typedef enum logic [1:0] {RATE_1_2, RATE_2_3, RATE_3_4} rate_class_e;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [3:0]    user;
    logic          last;
  } entry_t;

  logic [5:0]       hist_q, hist_d;
  logic             in_pkt_q, in_pkt_d;
  logic [3:0]       rate_q, rate_d;
  logic [1:0]       occ_q, occ_d;
  logic             ready_q, ready_d;
  entry_t           head_q, head_d, tail_q, tail_d;

  logic [3:0]       beat_rate;
  rate_class_e      rclass;
  logic [WIDTH+5:0] ext;
  logic [WIDTH-1:0] enc_a, enc_b;
  logic [OW-1:0]    p12, p23, p34, coded;
  entry_t           new_entry;
  logic             accept, pop;

  assign accept    = s_axis_tvalid & ready_q;
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign beat_rate = in_pkt_q ? rate_q : s_axis_tuser;

  // ext[k+6] is input bit k; ext[5:0] holds the six previous bits, oldest at bit 0.
  assign ext = {s_axis_tdata, hist_q};

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_enc
    assign enc_a[gi]     = ^(ext[gi +: 7] & GEN_A);
    assign enc_b[gi]     = ^(ext[gi +: 7] & GEN_B);
    assign p12[2*gi]     = enc_a[gi];
    assign p12[2*gi + 1] = enc_b[gi];
  end

  for (gi = 0; gi < WIDTH / 2; gi++) begin : g_p23
    assign p23[3*gi]     = enc_a[2*gi];
    assign p23[3*gi + 1] = enc_b[2*gi];
    assign p23[3*gi + 2] = enc_a[2*gi + 1];
  end
  assign p23[OW-1:W23] = '0;

  for (gi = 0; gi < WIDTH / 3; gi++) begin : g_p34
    assign p34[4*gi]     = enc_a[3*gi];
    assign p34[4*gi + 1] = enc_b[3*gi];
    assign p34[4*gi + 2] = enc_a[3*gi + 1];
    assign p34[4*gi + 3] = enc_b[3*gi + 2];
  end
  assign p34[OW-1:W34] = '0;

  always_comb begin
    rclass = RATE_1_2;
    unique case (beat_rate)
      4'b0001:                            rclass = RATE_2_3;
      4'b1111, 4'b0111, 4'b1011, 4'b0011: rclass = RATE_3_4;
      default:                            rclass = RATE_1_2;
    endcase
  end

  always_comb begin
    coded = p12;
    unique case (rclass)
      RATE_2_3: coded = p23;
      RATE_3_4: coded = p34;
      default:  coded = p12;
    endcase
  end

  assign new_entry = {coded, beat_rate, s_axis_tlast};

  // History and rate only move on an accepted beat; tlast returns the encoder to zero state.
  always_comb begin
    hist_d   = hist_q;
    in_pkt_d = in_pkt_q;
    rate_d   = rate_q;
    if (accept) begin
      hist_d   = s_axis_tlast ? 6'd0 : s_axis_tdata[WIDTH-1 -: 6];
      in_pkt_d = ~s_axis_tlast;
      rate_d   = beat_rate;
    end
  end

  // Skid buffer: head feeds the outputs directly, tail only fills while the head is stalled.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({accept, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = new_entry;
        else               tail_d = new_entry;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = new_entry;
        end else begin
          head_d = new_entry;
        end
      end
      default: ;
    endcase
    ready_d = (occ_d < 2'd2);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hist_q   <= '0;
      in_pkt_q <= 1'b0;
      rate_q   <= '0;
      occ_q    <= '0;
      ready_q  <= 1'b0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      hist_q   <= hist_d;
      in_pkt_q <= in_pkt_d;
      rate_q   <= rate_d;
      occ_q    <= occ_d;
      ready_q  <= ready_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = (occ_q != 2'd0);
  assign m_axis_tdata  = head_q.data;
  assign m_axis_tuser  = head_q.user;
  assign m_axis_tlast  = head_q.last;

endmodule

// File: tb/tb_conv_encoder_multirate.sv
// Randomised self-checking bench for conv_encoder_multirate against a bit-level reference model.
module tb_conv_encoder_multirate;
  localparam int W = 24;
  localparam logic [6:0] GA = 7'o133;
  localparam logic [6:0] GB = 7'o171;
  localparam logic [3:0] R6 = 4'b1101, R9 = 4'b1111, R48 = 4'b0001;

  logic           aclk = 1'b0, aresetn = 1'b0;
  logic [W-1:0]   s_tdata = '0;
  logic [3:0]     s_tuser = '0;
  logic           s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [2*W-1:0] m_tdata;
  logic [3:0]     m_tuser;
  logic           m_tvalid, m_tlast, m_tready = 1'b1;

  conv_encoder_multirate #(.WIDTH(W), .GEN_A(GA), .GEN_B(GB)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [2*W-1:0] data;
    logic [3:0]     user;
    logic           last;
  } obeat_t;

  int checks = 0, errors = 0;
  int occ = 0;
  bit mh[6];            // mh[j] is the input bit j+1 steps in the past
  bit m_inpkt = 1'b0;
  logic [3:0] m_rate = '0;
  obeat_t exp_q[$], obs_q[$];
  int acc_cyc[$], obs_cyc[$];
  logic [W-1:0] in_data[$];
  logic [3:0] in_user[$];
  logic in_last[$];

  task automatic model_reset();
    for (int j = 0; j < 6; j++) mh[j] = 1'b0;
    m_inpkt = 1'b0;
    m_rate = '0;
    occ = 0;
  endtask

  task automatic clear_queues();
    exp_q.delete(); obs_q.delete(); acc_cyc.delete(); obs_cyc.delete();
    in_data.delete(); in_user.delete(); in_last.delete();
  endtask

  // Encode one beat bit by bit, then keep bits according to the puncture pattern of the rate.
  task automatic model_accept(input logic [W-1:0] d, input logic [3:0] u, input logic l);
    bit x[W+6];
    bit a[W];
    bit b[W];
    logic [2*W-1:0] o;
    logic [3:0] r;
    int p;
    obeat_t e;
    for (int i = 0; i < 6; i++) x[i] = mh[5-i];
    for (int n = 0; n < W; n++) x[n+6] = d[n];
    for (int n = 0; n < W; n++) begin
      a[n] = 1'b0; b[n] = 1'b0;
      for (int k = 0; k <= 6; k++) begin
        if (GA[6-k]) a[n] = a[n] ^ x[n+6-k];
        if (GB[6-k]) b[n] = b[n] ^ x[n+6-k];
      end
    end
    r = m_inpkt ? m_rate : u;
    m_rate = r;
    o = '0; p = 0;
    case (r)
      4'b0001:
        for (int g = 0; g < W; g += 2) begin
          o[p] = a[g]; o[p+1] = b[g]; o[p+2] = a[g+1]; p += 3;
        end
      4'b1111, 4'b0111, 4'b1011, 4'b0011:
        for (int g = 0; g < W; g += 3) begin
          o[p] = a[g]; o[p+1] = b[g]; o[p+2] = a[g+1]; o[p+3] = b[g+2]; p += 4;
        end
      default:
        for (int n = 0; n < W; n++) begin
          o[2*n] = a[n]; o[2*n+1] = b[n];
        end
    endcase
    for (int j = 0; j < 6; j++) mh[j] = l ? 1'b0 : d[W-1-j];
    m_inpkt = !l;
    e.data = o; e.user = r; e.last = l;
    exp_q.push_back(e);
  endtask

  // mode: 0 ready always, 1 ready one cycle in three, 2 random ready, 3 ready never.
  task automatic run_stream(input int mode, input int max_cyc, output int rdy_bad,
                            output int rdy_low, output int stall_bad, output int timed_out);
    int sent = 0, cyc = 0;
    bit stalled = 1'b0;
    obeat_t held = '0, cur;
    rdy_bad = 0; rdy_low = 0; stall_bad = 0; timed_out = 0;
    forever begin
      if (sent < in_data.size()) begin
        s_tvalid = 1'b1; s_tdata = in_data[sent]; s_tuser = in_user[sent]; s_tlast = in_last[sent];
      end else begin
        s_tvalid = 1'b0; s_tdata = W'($urandom); s_tuser = 4'($urandom); s_tlast = 1'($urandom);
      end
      case (mode)
        0: m_tready = 1'b1;
        1: m_tready = (cyc % 3 == 2);
        2: m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
      @(negedge aclk);
      if (s_tready !== (occ < 2)) rdy_bad++;
      if (s_tready === 1'b0) rdy_low++;
      cur.data = m_tdata; cur.user = m_tuser; cur.last = m_tlast;
      if (stalled && (m_tvalid !== 1'b1 || cur !== held)) stall_bad++;
      stalled = m_tvalid && !m_tready;
      held = cur;
      if (m_tvalid && m_tready) begin
        obs_q.push_back(cur); obs_cyc.push_back(cyc); occ--;
      end
      if (s_tvalid && s_tready) begin
        model_accept(s_tdata, s_tuser, s_tlast); acc_cyc.push_back(cyc); sent++; occ++;
      end
      cyc++;
      @(posedge aclk); #1;
      if (sent == in_data.size() && (mode == 3 || obs_q.size() >= exp_q.size())) break;
      if (cyc >= max_cyc) begin timed_out = 1; break; end
    end
    s_tvalid = 1'b0;
    m_tready = (mode != 3);
  endtask

  task automatic add_beat(input logic [W-1:0] d, input logic [3:0] u, input logic l);
    in_data.push_back(d); in_user.push_back(u); in_last.push_back(l);
  endtask

  task automatic add_random_beats(input int n);
    for (int i = 0; i < n; i++)
      add_beat(W'($urandom), 4'($urandom_range(0, 15)), (i == n-1) ? 1'b1 : ($urandom_range(0, 3) == 0));
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%h want=0", m_tdata); end
    checks++; if (m_tuser !== 4'd0) begin errors++; $display("FAIL reset_tuser got=%h want=0", m_tuser); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b want=0", m_tlast); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%b want=0", s_tready); end
    aresetn = 1'b1;
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL release_tready got=%b want=1", s_tready); end
    $display("test_reset: done");
  endtask

  task automatic test_impulse();
    logic [3:0] rt[3];
    logic [2*W-1:0] ex[3];
    int rb, rl, sb, to;
    rt = '{R6, R9, R48};
    ex = '{48'h0000000034FB, 48'h00000000033B, 48'h00000000073B};
    for (int i = 0; i < 3; i++) begin
      clear_queues();
      add_beat(24'h000001, rt[i], 1'b1);
      run_stream(0, 20, rb, rl, sb, to);
      checks++;
      if (to != 0 || obs_q.size() != 1) begin
        errors++; $display("FAIL impulse_count rate=%b got=%0d want=1 timeout=%0d", rt[i], obs_q.size(), to);
      end else begin
        checks++; if (obs_q[0].data !== ex[i]) begin errors++; $display("FAIL impulse_data rate=%b got=%h want=%h", rt[i], obs_q[0].data, ex[i]); end
        checks++; if (obs_q[0].user !== rt[i]) begin errors++; $display("FAIL impulse_tuser got=%b want=%b", obs_q[0].user, rt[i]); end
        checks++; if (obs_q[0].last !== 1'b1) begin errors++; $display("FAIL impulse_tlast got=%b want=1", obs_q[0].last); end
        checks++; if (obs_cyc[0] != acc_cyc[0] + 1) begin errors++; $display("FAIL impulse_latency got=%0d want=1", obs_cyc[0] - acc_cyc[0]); end
      end
      $display("test_impulse: rate=%b out=%h", rt[i], (obs_q.size() > 0) ? obs_q[0].data : '0);
    end
  endtask

  task automatic test_history();
    logic [2*W-1:0] ex1[2];
    int rb, rl, sb, to;
    ex1 = '{48'h000000000D3E, 48'h000000000000};
    for (int v = 0; v < 2; v++) begin
      clear_queues();
      add_beat(24'h800000, R6, v == 1);
      add_beat(24'h000000, R6, 1'b1);
      run_stream(0, 20, rb, rl, sb, to);
      checks++;
      if (to != 0 || obs_q.size() != 2) begin
        errors++; $display("FAIL history_count got=%0d want=2", obs_q.size());
      end else begin
        checks++; if (obs_q[0].data !== 48'hC00000000000) begin errors++; $display("FAIL history_out0 got=%h want=%h", obs_q[0].data, 48'hC00000000000); end
        checks++; if (obs_q[1].data !== ex1[v]) begin errors++; $display("FAIL history_out1 v=%0d got=%h want=%h", v, obs_q[1].data, ex1[v]); end
      end
      $display("test_history: tlast_on_beat0=%0d done", v);
    end
  endtask

  task automatic compare_all(input string tag);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_count got=%0d want=%0d", tag, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s_beat%0d got=%h want=%h", tag, i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int rb, rl, sb, to;
    clear_queues();
    add_random_beats(10);
    run_stream(0, 40, rb, rl, sb, to);
    checks++; if (to != 0) begin errors++; $display("FAIL b2b_timeout got=%0d want=0", to); end
    compare_all("b2b");
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] != obs_cyc[0] + i) begin errors++; $display("FAIL b2b_gap beat=%0d got=%0d want=%0d", i, obs_cyc[i], obs_cyc[0] + i); end
    end
    $display("test_back_to_back: %0d outputs", obs_q.size());
  endtask

  task automatic test_backpressure();
    int rb, rl, sb, to;
    clear_queues();
    add_random_beats(10);
    run_stream(1, 100, rb, rl, sb, to);
    checks++; if (to != 0) begin errors++; $display("FAIL bp_timeout got=%0d want=0", to); end
    checks++; if (rb != 0) begin errors++; $display("FAIL bp_ready_vs_occupancy got=%0d want=0", rb); end
    checks++; if (rl == 0) begin errors++; $display("FAIL bp_ready_never_dropped got=%0d want>0", rl); end
    checks++; if (sb != 0) begin errors++; $display("FAIL bp_stall_stability got=%0d want=0", sb); end
    compare_all("bp");
    $display("test_backpressure: %0d outputs, ready low %0d cycles", obs_q.size(), rl);
  endtask

  task automatic test_rate_latch();
    int rb, rl, sb, to;
    clear_queues();
    add_beat(W'($urandom), R6, 1'b0);
    add_beat(W'($urandom), R9, 1'b0);
    add_beat(W'($urandom), R9, 1'b1);
    run_stream(0, 20, rb, rl, sb, to);
    compare_all("latch");
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].user !== R6) begin errors++; $display("FAIL latch_tuser beat=%0d got=%b want=%b", i, obs_q[i].user, R6); end
    end
    $display("test_rate_latch: %0d outputs", obs_q.size());
  endtask

  task automatic test_reset_midpacket();
    int rb, rl, sb, to;
    clear_queues();
    add_beat(24'h800000, R6, 1'b0);
    add_beat(W'($urandom), R6, 1'b0);
    run_stream(3, 20, rb, rl, sb, to);
    @(negedge aclk);
    #1 aresetn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midreset_tvalid got=%b want=0", m_tvalid); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL midreset_tready got=%b want=0", s_tready); end
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    m_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    clear_queues();
    add_beat(24'h000001, R6, 1'b1);
    run_stream(0, 20, rb, rl, sb, to);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== 48'h0000000034FB) begin
      errors++; $display("FAIL midreset_impulse got=%h count=%0d want=%h", (obs_q.size() > 0) ? obs_q[0].data : '0, obs_q.size(), 48'h0000000034FB);
    end
    $display("test_reset_midpacket: done");
  endtask

  task automatic test_random_traffic();
    int rb, rl, sb, to;
    clear_queues();
    add_random_beats(60);
    run_stream(2, 1000, rb, rl, sb, to);
    checks++; if (to != 0) begin errors++; $display("FAIL rand_timeout got=%0d want=0", to); end
    checks++; if (rb != 0) begin errors++; $display("FAIL rand_ready_vs_occupancy got=%0d want=0", rb); end
    checks++; if (sb != 0) begin errors++; $display("FAIL rand_stall_stability got=%0d want=0", sb); end
    compare_all("rand");
    $display("test_random_traffic: %0d outputs", obs_q.size());
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_history();
    test_back_to_back();
    test_backpressure();
    test_rate_latch();
    test_reset_midpacket();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
